// File: rtl/jesd204_rx_pkg.sv
// Shared types and control characters for the JESD204B receive lane.
package jesd204_rx_pkg;

    localparam logic [7:0] K_CHAR = 8'hBC;
    localparam logic [7:0] R_CHAR = 8'h1C;
    localparam logic [7:0] Q_CHAR = 8'h9C;
    localparam logic [7:0] A_CHAR = 8'h7C;
    localparam logic [7:0] F_CHAR = 8'hFC;

    typedef enum logic [1:0] {
        ST_CGS    = 2'd0,
        ST_WAIT_R = 2'd1,
        ST_ILAS   = 2'd2,
        ST_DATA   = 2'd3
    } rx_state_t;

    typedef logic [3:0][7:0] word_t;

    typedef struct packed {
        logic       err;
        logic       k;
        logic [7:0] d;
    } lane_t;

    typedef lane_t [3:0] lword_t;

    // A control character only counts when it decoded cleanly.
    function automatic logic is_char(lane_t l, logic [7:0] c);
        return l.k && !l.err && (l.d == c);
    endfunction

    // Run length of consecutive /K/ octets, saturating at 4.
    function automatic logic [2:0] k_run(logic [2:0] cnt, lword_t w);
        logic [2:0] c;
        c = cnt;
        for (int i = 0; i < 4; i++) begin
            if (is_char(w[i], K_CHAR)) c = (c == 3'd4) ? 3'd4 : c + 3'd1;
            else                       c = 3'd0;
        end
        return c;
    endfunction

endpackage

// File: rtl/jesd204_rx_align.sv
// Octet realigner: offset register plus {cur,prev} mux, one registered stage.
module jesd204_rx_align
    import jesd204_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [1:0] off_i,
    input  lword_t     word_i,
    output lword_t     word_o
);

    logic [1:0] off_q;
    logic [1:0] off_sel;
    logic [2:0] idx;
    lword_t     prev_q;
    lword_t     word_q;
    lword_t     algn_d;

    // Offset 0 needs no previous word, so the current word passes straight through.
    always_comb begin
        off_sel = load_i ? off_i : off_q;
        idx     = 3'd0;
        algn_d  = word_i;
        for (int j = 0; j < 4; j++) begin
            idx = {1'b0, off_sel} + 3'(j);
            if (!idx[2]) algn_d[j] = prev_q[idx[1:0]];
            else         algn_d[j] = word_i[idx[1:0]];
        end
        if (off_sel == 2'd0) algn_d = word_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_q  <= 2'd0;
            prev_q <= '0;
            word_q <= '0;
        end else begin
            prev_q <= word_i;
            word_q <= algn_d;
            if (load_i) off_q <= off_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/jesd204_rx_lane.sv
// JESD204B per-lane receive link layer: CGS, ILAS capture/check, character
// replacement and error accounting on the realigned word stream.
module jesd204_rx_lane
    import jesd204_rx_pkg::*;
#(
    parameter int unsigned K       = 32,
    parameter int unsigned ILAS_MF = 4,
    parameter int unsigned ERR_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  word_t             DI,
    input  logic [3:0]        DK,
    input  logic [3:0]        DERR,
    input  logic              RESYNC,
    output logic              SYNC_n,
    output word_t             DO,
    output logic              DV,
    output logic              SOMF,
    output logic [13:0][7:0]  CFG,
    output logic              CFG_VLD,
    output logic [7:0]        ERR_CNT,
    output logic [1:0]        STATE
);

    localparam int unsigned WCW = $clog2(K);
    localparam int unsigned MFW = (ILAS_MF > 2) ? $clog2(ILAS_MF) : 1;

    rx_state_t       state_q;
    logic [WCW-1:0]  wc_q;
    logic [MFW-1:0]  mfc_q;
    logic [2:0]      kcnt_q;
    logic [4:0]      mf_err_q;
    logic            skip_q;

    lword_t          raw_w;
    lword_t          algn_w;
    logic            r_found, r_bad, load;
    logic [1:0]      r_pos;
    logic            wc_last, ilas_bad;
    logic [3:0]      cidx;
    logic [13:0][7:0] cfg_d;
    logic            k3, rep;
    logic [2:0]      n_err;
    logic [4:0]      mf_err_sum;
    logic [8:0]      err_sum;
    word_t           do_d;
    logic [2:0]      krun_nxt;
    logic            drop;

    always_comb begin
        for (int i = 0; i < 4; i++) raw_w[i] = {DERR[i], DK[i], DI[i]};
    end

    // First /R/ in time order, with only /K/ allowed ahead of it.
    always_comb begin
        r_found = 1'b0;
        r_bad   = 1'b0;
        r_pos   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_found && !r_bad) begin
                if (is_char(raw_w[i], R_CHAR)) begin
                    r_found = 1'b1;
                    r_pos   = 2'(i);
                end else if (!is_char(raw_w[i], K_CHAR)) begin
                    r_bad = 1'b1;
                end
            end
        end
    end

    assign load = (state_q == ST_WAIT_R) && r_found && !RESYNC;

    jesd204_rx_align u_align (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (load),
        .off_i  (r_pos),
        .word_i (raw_w),
        .word_o (algn_w)
    );

    assign wc_last = (wc_q == WCW'(K - 1));

    // ILAS framing checks and config capture (c0,c1 in word 0, c2..c13 in words 1..3).
    always_comb begin
        ilas_bad = 1'b0;
        for (int l = 0; l < 4; l++) if (algn_w[l].err) ilas_bad = 1'b1;
        if (wc_q == '0 && !is_char(algn_w[0], R_CHAR)) ilas_bad = 1'b1;
        if (wc_last && !is_char(algn_w[3], A_CHAR))    ilas_bad = 1'b1;
        if (mfc_q == MFW'(1) && wc_q == '0 && !is_char(algn_w[1], Q_CHAR)) ilas_bad = 1'b1;
        cfg_d = CFG;
        cidx  = 4'd0;
        for (int l = 0; l < 4; l++) begin
            cidx = {wc_q[1:0], 2'(l)} - 4'd2;
            if (wc_q <= WCW'(3) && !(wc_q == '0 && l < 2)) cfg_d[cidx] = algn_w[l].d;
        end
    end

    // Replacement on octet 3 and per-octet error count for the data word.
    always_comb begin
        k3   = algn_w[3].k && !algn_w[3].err;
        rep  = k3 && ((algn_w[3].d == A_CHAR && wc_last) ||
                      (algn_w[3].d == F_CHAR && !wc_last));
        n_err = 3'(algn_w[0].err) + 3'(algn_w[1].err) + 3'(algn_w[2].err)
              + 3'(algn_w[3].err) + 3'(k3 && !rep);
        mf_err_sum = ((wc_q == '0) ? 5'd0 : mf_err_q) + 5'(n_err);
        err_sum    = 9'(ERR_CNT) + 9'(n_err);
        for (int l = 0; l < 4; l++) do_d[l] = algn_w[l].d;
        if (rep) do_d[3] = DO[3];
        krun_nxt = k_run(kcnt_q, (state_q == ST_CGS) ? raw_w : algn_w);
    end

    always_comb begin
        drop = RESYNC;
        case (state_q)
            ST_WAIT_R: if (!r_found && r_bad) drop = 1'b1;
            ST_ILAS:   if (!skip_q && ilas_bad) drop = 1'b1;
            ST_DATA:   if (mf_err_sum >= 5'(ERR_MAX) || krun_nxt == 3'd4) drop = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_CGS;
            wc_q     <= '0;
            mfc_q    <= '0;
            kcnt_q   <= 3'd0;
            mf_err_q <= 5'd0;
            skip_q   <= 1'b0;
            SYNC_n   <= 1'b0;
            DO       <= '0;
            DV       <= 1'b0;
            SOMF     <= 1'b0;
            CFG      <= '0;
            CFG_VLD  <= 1'b0;
            ERR_CNT  <= 8'd0;
        end else begin
            if (state_q == ST_DATA && !RESYNC)
                ERR_CNT <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if (drop) begin
                state_q <= ST_CGS;
                kcnt_q  <= 3'd0;
                skip_q  <= 1'b0;
                SYNC_n  <= 1'b0;
                DV      <= 1'b0;
                SOMF    <= 1'b0;
                CFG_VLD <= 1'b0;
            end else begin
                case (state_q)
                    ST_CGS: begin
                        kcnt_q <= krun_nxt;
                        if (krun_nxt == 3'd4) begin
                            state_q <= ST_WAIT_R;
                            SYNC_n  <= 1'b1;
                        end
                    end
                    ST_WAIT_R: begin
                        if (r_found) begin
                            state_q <= ST_ILAS;
                            wc_q    <= '0;
                            mfc_q   <= '0;
                            skip_q  <= (r_pos != 2'd0);
                        end
                    end
                    ST_ILAS: begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            if (mfc_q == MFW'(1)) CFG <= cfg_d;
                            if (wc_last) begin
                                wc_q <= '0;
                                if (mfc_q == MFW'(1)) CFG_VLD <= 1'b1;
                                if (mfc_q == MFW'(ILAS_MF - 1)) begin
                                    state_q  <= ST_DATA;
                                    kcnt_q   <= 3'd0;
                                    mf_err_q <= 5'd0;
                                end else begin
                                    mfc_q <= mfc_q + MFW'(1);
                                end
                            end else begin
                                wc_q <= wc_q + WCW'(1);
                            end
                        end
                    end
                    default: begin
                        DV       <= 1'b1;
                        SOMF     <= (wc_q == '0);
                        DO       <= do_d;
                        mf_err_q <= mf_err_sum;
                        kcnt_q   <= krun_nxt;
                        wc_q     <= wc_last ? '0 : wc_q + WCW'(1);
                    end
                endcase
            end
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_jesd204_rx_lane.sv
// Directed bench for jesd204_rx_lane: octet-stream driver with hand-computed checks.
module tb_jesd204_rx_lane;
    import jesd204_rx_pkg::*;

    logic             CLK = 1'b0;
    logic             RST, RESYNC;
    word_t            DI;
    logic [3:0]       DK, DERR;
    logic             SYNC_n, DV, SOMF, CFG_VLD;
    word_t            DO;
    logic [13:0][7:0] CFG;
    logic [7:0]       ERR_CNT;
    logic [1:0]       STATE;

    int total = 0;
    int bad   = 0;
    int nw    = 0;
    int base  = 0;
    logic [9:0] q[$];
    logic [13:0][7:0] cfg_exp;
    word_t w_exp;

    always #5 CLK = ~CLK;

    jesd204_rx_lane #(.K(32), .ILAS_MF(4), .ERR_MAX(4)) dut (
        .CLK(CLK), .RST(RST), .DI(DI), .DK(DK), .DERR(DERR), .RESYNC(RESYNC),
        .SYNC_n(SYNC_n), .DO(DO), .DV(DV), .SOMF(SOMF), .CFG(CFG),
        .CFG_VLD(CFG_VLD), .ERR_CNT(ERR_CNT), .STATE(STATE)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dval(input int j, input int l);
        return 8'(128 + j * 4 + l);
    endfunction

    task automatic push(input logic [7:0] d, input logic k, input logic e);
        q.push_back({e, k, d});
    endtask

    task automatic drive_word();
        logic [9:0] v;
        for (int l = 0; l < 4; l++) begin
            v = (q.size() > 0) ? q.pop_front() : 10'd0;
            DI[l] = v[7:0]; DK[l] = v[8]; DERR[l] = v[9];
        end
        @(posedge CLK); #1;
        nw++;
    endtask

    task automatic drive_to(input int n);
        while (nw < n) drive_word();
    endtask

    task automatic do_reset();
        q.delete();
        RST = 1'b1; RESYNC = 1'b0; DI = '0; DK = 4'd0; DERR = 4'd0;
        @(posedge CLK); #1;
        RST = 1'b0;
        nw = 0;
    endtask

    // 14 /K/ octets put the following /R/ at lane 2 of the fourth word.
    task automatic push_sync();
        for (int i = 0; i < 14; i++) push(K_CHAR, 1'b1, 1'b0);
    endtask

    task automatic push_ilas(input int bad_mf);
        for (int m = 0; m < 4; m++)
            for (int w = 0; w < 32; w++)
                for (int l = 0; l < 4; l++) begin
                    if (w == 0 && l == 0)                    push(R_CHAR, 1'b1, 1'b0);
                    else if (m == 1 && w == 0 && l == 1)     push(Q_CHAR, 1'b1, 1'b0);
                    else if (m == 1 && w < 4)                push(8'(16 + w * 4 + l - 2), 1'b0, 1'b0);
                    else if (w == 31 && l == 3 && m != bad_mf) push(A_CHAR, 1'b1, 1'b0);
                    else                                     push(8'(64 + w), 1'b0, 1'b0);
                end
    endtask

    task automatic push_data(input int j, input logic [7:0] d3, input logic k3, input logic [3:0] e);
        for (int l = 0; l < 3; l++) push(dval(j, l), 1'b0, e[l]);
        push(d3, k3, e[3]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  STATE,   2'd0);
        check({tag, "_sync"},   SYNC_n,  1'b0);
        check({tag, "_dv"},     DV,      1'b0);
        check({tag, "_somf"},   SOMF,    1'b0);
        check({tag, "_do"},     DO,      '0);
        check({tag, "_cfg"},    CFG,     '0);
        check({tag, "_cfgvld"}, CFG_VLD, 1'b0);
        check({tag, "_errcnt"}, ERR_CNT, 8'd0);
    endtask

    initial begin
        for (int i = 0; i < 14; i++) cfg_exp[i] = 8'(16 + i);

        // Link-up, replacement and tolerated error rate
        do_reset();
        check_reset("rst");
        push_sync();
        push_ilas(-1);
        for (int j = 0; j < 352; j++) begin
            if (j == 5)       push_data(j, 8'h5A, 1'b0, 4'b0000);
            else if (j == 6)  push_data(j, F_CHAR, 1'b1, 4'b0000);
            else if (j == 30) push_data(j, 8'h3C, 1'b0, 4'b0000);
            else if (j == 31) push_data(j, A_CHAR, 1'b1, 4'b0000);
            else if (j >= 32 && (j % 32 == 2 || j % 32 == 10 || j % 32 == 20))
                push_data(j, dval(j, 3), 1'b0, 4'b0010);
            else              push_data(j, dval(j, 3), 1'b0, 4'b0000);
        end
        drive_word();
        check("cgs_sync_n", SYNC_n, 1'b1);
        check("cgs_state",  STATE,  2'd1);
        drive_to(3);
        check("waitr_state", STATE, 2'd1);
        drive_word();
        check("ilas_entry", STATE, 2'd2);
        while (DV !== 1'b1 && nw < 300) drive_word();
        check("dv_latency", nw, 134);
        check("data_state", STATE, 2'd3);
        check("data_somf0", SOMF, 1'b1);
        check("data_do0", DO[0], dval(0, 0));
        for (int l = 0; l < 4; l++) w_exp[l] = dval(0, l);
        check("data_w0", DO, w_exp);
        check("cfg", CFG, cfg_exp);
        check("cfg_vld", CFG_VLD, 1'b1);
        base = nw;
        drive_to(base + 1);
        check("somf_w1", SOMF, 1'b0);
        drive_to(base + 6);
        check("f_repl", DO[3], 8'h5A);
        check("f_errcnt", ERR_CNT, 8'd0);
        drive_to(base + 31);
        check("a_repl", DO[3], 8'h3C);
        check("a_errcnt", ERR_CNT, 8'd0);
        drive_to(base + 32);
        check("somf_mf1", SOMF, 1'b1);
        drive_to(base + 351);
        check("err30_state", STATE, 2'd3);
        check("err30_cnt", ERR_CNT, 8'd30);
        check("err30_dv", DV, 1'b1);

        // Missing /A/ at the end of ILAS multiframe 2
        do_reset();
        push_sync();
        push_ilas(2);
        drive_to(69);
        check("ilasbad_cfgvld1", CFG_VLD, 1'b1);
        drive_to(100);
        check("ilasbad_pre", STATE, 2'd2);
        drive_to(101);
        check("ilasbad_state", STATE, 2'd0);
        check("ilasbad_sync", SYNC_n, 1'b0);
        check("ilasbad_cfgvld", CFG_VLD, 1'b0);

        // Four DERR octets in one multiframe force resync
        do_reset();
        push_sync();
        push_ilas(-1);
        for (int j = 0; j < 40; j++)
            push_data(j, dval(j, 3), 1'b0, (j >= 3 && j <= 6) ? 4'b0001 : 4'b0000);
        drive_to(134 + 5);
        check("err4_pre_state", STATE, 2'd3);
        check("err4_pre_cnt", ERR_CNT, 8'd3);
        drive_to(134 + 6);
        check("err4_state", STATE, 2'd0);
        check("err4_cnt", ERR_CNT, 8'd4);
        check("err4_dv", DV, 1'b0);
        check("err4_sync", SYNC_n, 1'b0);

        // RST on the /R/ cycle returns every output to its reset value
        q.delete();
        nw = 0;
        push_sync();
        push(R_CHAR, 1'b1, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        drive_to(3);
        check("rstr_pre", STATE, 2'd1);
        RST = 1'b1;
        drive_word();
        RST = 1'b0;
        check_reset("rstr");

        // RESYNC on the /R/ cycle wins over entering ILAS
        do_reset();
        push_sync();
        push(R_CHAR, 1'b1, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        drive_to(3);
        check("resync_pre", STATE, 2'd1);
        RESYNC = 1'b1;
        drive_word();
        RESYNC = 1'b0;
        check("resync_state", STATE, 2'd0);
        check("resync_sync", SYNC_n, 1'b0);
        drive_word();
        check("resync_hold", STATE, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
